// File: rtl/data_mem_resp.sv
// data_mem_resp: the data-memory responder for the single-cycle core.
// Loads are combinational. Stores and all register updates happen on the
// rising clock edge. Byte addresses 0x000-0x1EF map to on-chip RAM, and
// 0x1F0-0x1FF map to the peripheral block (cnt, cmp, status, led).
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   memwrite    store request this cycle
//   memread     load request this cycle
//   memop       RISC-V funct3 size/sign code (B, H, W, BU, HU)
//   memaddr     9-bit byte address
//   memdatain   store data, right-aligned
//   memdataout  load data, extended according to memop (0 when not reading)
//   led         LED register
//   irq         status[0], sticky compare-match bit
//   err         status[1], sticky access-error bit
module data_mem_resp #(
  parameter int RAM_WORDS = 124,
  parameter int LED_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memwrite,
  input  logic             memread,
  input  logic [2:0]       memop,
  input  logic [8:0]       memaddr,
  input  logic [31:0]      memdatain,
  output logic [31:0]      memdataout,
  output logic [LED_W-1:0] led,
  output logic             irq,
  output logic             err
);

  typedef enum logic [2:0] {
    OP_B  = 3'b000,
    OP_H  = 3'b001,
    OP_W  = 3'b010,
    OP_BU = 3'b100,
    OP_HU = 3'b101
  } memop_e;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] cnt;
  logic [31:0] cmp;
  logic [1:0]  status;

  logic [6:0]  widx;
  logic        is_mmio;
  logic        ram_hit;
  logic        align_ok;
  logic        is_word;
  logic        op_ld_ok;
  logic        op_st_ok;
  logic        load_ok;
  logic        store_ok;
  logic [31:0] rd_word;
  logic [31:0] shifted;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ram_we;
  logic        mmio_we;
  logic        acc_err;
  logic        match;
  logic [1:0]  w1c;

  assign widx    = memaddr[8:2];
  assign is_mmio = (memaddr[8:4] == 5'h1F);
  // The MMIO window is excluded from the RAM decode, so a full-size RAM
  // never aliases it. Smaller RAMs leave a hole that reads as zero.
  assign ram_hit = !is_mmio && (32'(widx) < RAM_WORDS);

  always_comb begin
    align_ok = 1'b0;
    is_word  = 1'b0;
    op_ld_ok = 1'b0;
    op_st_ok = 1'b0;
    case (memop)
      OP_B:  begin align_ok = 1'b1;                 op_ld_ok = 1'b1; op_st_ok = 1'b1; end
      OP_BU: begin align_ok = 1'b1;                 op_ld_ok = 1'b1;                  end
      OP_H:  begin align_ok = ~memaddr[0];          op_ld_ok = 1'b1; op_st_ok = 1'b1; end
      OP_HU: begin align_ok = ~memaddr[0];          op_ld_ok = 1'b1;                  end
      OP_W:  begin align_ok = (memaddr[1:0] == 2'b00); is_word = 1'b1;
                   op_ld_ok = 1'b1; op_st_ok = 1'b1; end
      default: ;
    endcase
  end

  assign load_ok  = op_ld_ok && align_ok && (!is_mmio || is_word);
  assign store_ok = op_st_ok && align_ok && (!is_mmio || is_word);

  always_comb begin
    rd_word = '0;
    if (is_mmio) begin
      case (memaddr[3:2])
        2'd0: rd_word = cnt;
        2'd1: rd_word = cmp;
        2'd2: rd_word = {30'b0, status};
        default: rd_word = 32'(led);
      endcase
    end else if (ram_hit) begin
      rd_word = ram[widx];
    end
  end

  // Bring the addressed byte or half-word down to bit 0 before extending.
  assign shifted = rd_word >> {memaddr[1:0], 3'b000};

  always_comb begin
    memdataout = '0;
    if (memread && load_ok) begin
      case (memop)
        OP_B:    memdataout = {{24{shifted[7]}}, shifted[7:0]};
        OP_BU:   memdataout = {24'b0, shifted[7:0]};
        OP_H:    memdataout = {{16{shifted[15]}}, shifted[15:0]};
        OP_HU:   memdataout = {16'b0, shifted[15:0]};
        default: memdataout = rd_word;
      endcase
    end
  end

  // Store data is replicated across lanes, and the byte enables choose
  // which lanes actually get written.
  always_comb begin
    wdata = memdatain;
    be    = 4'b1111;
    case (memop)
      OP_B: begin
        wdata = {4{memdatain[7:0]}};
        be    = 4'b0001 << memaddr[1:0];
      end
      OP_H: begin
        wdata = {2{memdatain[15:0]}};
        be    = memaddr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign ram_we  = memwrite && store_ok && ram_hit;
  assign mmio_we = memwrite && store_ok && is_mmio;
  assign acc_err = (memread && !load_ok) || (memwrite && !store_ok);
  assign match   = (cnt == cmp);
  assign w1c     = (mmio_we && memaddr[3:2] == 2'd2) ? memdatain[1:0] : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram    <= '{default: '0};
      cnt    <= '0;
      cmp    <= '1;
      status <= '0;
      led    <= '0;
    end else begin
      if (ram_we) begin
        for (int unsigned l = 0; l < 4; l++) begin
          if (be[l]) ram[widx][8*l +: 8] <= wdata[8*l +: 8];
        end
      end
      cnt <= (mmio_we && memaddr[3:2] == 2'd0) ? memdatain : cnt + 32'd1;
      if (mmio_we && memaddr[3:2] == 2'd1) cmp <= memdatain;
      if (mmio_we && memaddr[3:2] == 2'd3) led <= memdatain[LED_W-1:0];
      // Clear first, then OR in the new sets, so a set on the same edge wins.
      status <= (status & ~w1c) | {acc_err, match};
    end
  end

  assign irq = status[0];
  assign err = status[1];

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwrite;
  logic        memread;
  logic [2:0]  memop;
  logic [8:0]  memaddr;
  logic [31:0] memdatain;
  logic [31:0] memdataout;
  logic [15:0] led;
  logic        irq;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: byte-addressed RAM image plus peripheral registers.
  logic [7:0]  mb [0:495];
  logic [31:0] m_cnt;
  logic [31:0] m_cmp;
  logic [1:0]  m_stat;
  logic [15:0] m_led;

  data_mem_resp #(.RAM_WORDS(124), .LED_W(16)) dut (
    .clk(clk), .rst(rst), .memwrite(memwrite), .memread(memread),
    .memop(memop), .memaddr(memaddr), .memdatain(memdatain),
    .memdataout(memdataout), .led(led), .irq(irq), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit legal(input bit st, input logic [2:0] op, input logic [8:0] a);
    int sz = op_size(op);
    if (sz == 0) return 0;
    if (st && (op == 3'd4 || op == 3'd5)) return 0;
    if (int'(a) % sz != 0) return 0;
    if (int'(a) >= 'h1F0 && sz != 4) return 0;
    return 1;
  endfunction

  function automatic logic [7:0] rb(input int ai);
    return (ai < 496) ? mb[ai] : 8'h00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [8:0] a);
    int ai = int'(a);
    logic [7:0]  b;
    logic [15:0] h;
    if (!legal(0, op, a)) return 32'h0;
    if (ai >= 'h1F0) begin
      case (ai)
        'h1F0:   return m_cnt;
        'h1F4:   return m_cmp;
        'h1F8:   return {30'b0, m_stat};
        default: return {16'b0, m_led};
      endcase
    end
    b = rb(ai);
    h = {rb(ai + 1), rb(ai)};
    case (op)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'b0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'b0, h};
      default: return {rb(ai + 3), rb(ai + 2), h};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 496; i++) mb[i] = 8'h00;
    m_cnt  = 32'h0;
    m_cmp  = 32'hFFFF_FFFF;
    m_stat = 2'b00;
    m_led  = 16'h0;
  endtask

  task automatic model_edge(input bit we, input bit re, input logic [2:0] op,
                            input logic [8:0] a, input logic [31:0] d);
    int          ai     = int'(a);
    bit          errset = (re && !legal(0, op, a)) || (we && !legal(1, op, a));
    bit          match  = (m_cnt == m_cmp);
    logic [1:0]  clr    = 2'b00;
    logic [31:0] ncnt   = m_cnt + 32'd1;
    if (we && legal(1, op, a)) begin
      if (ai >= 'h1F0) begin
        case (ai)
          'h1F0:   ncnt  = d;
          'h1F4:   m_cmp = d;
          'h1F8:   clr   = d[1:0];
          default: m_led = d[15:0];
        endcase
      end else begin
        for (int k = 0; k < op_size(op); k++)
          if (ai + k < 496) mb[ai + k] = d[8*k +: 8];
      end
    end
    m_stat = (m_stat & ~clr) | {errset, match};
    m_cnt  = ncnt;
  endtask

  // One bus cycle: entered and left at a falling edge.
  task automatic cyc(input bit we, input bit re, input logic [2:0] op,
                     input logic [8:0] a, input logic [31:0] d, output logic [31:0] rd);
    memwrite  = we;
    memread   = re;
    memop     = op;
    memaddr   = a;
    memdatain = d;
    #1;
    check("memdataout", memdataout, re ? model_load(op, a) : 32'h0);
    check("led", 32'(led), 32'(m_led));
    check("irq", 32'(irq), 32'(m_stat[0]));
    check("err", 32'(err), 32'(m_stat[1]));
    rd = memdataout;
    @(posedge clk);
    model_edge(we, re, op, a, d);
    @(negedge clk);
  endtask

  task automatic st(input logic [2:0] op, input logic [8:0] a, input logic [31:0] d);
    logic [31:0] rd;
    cyc(1'b1, 1'b0, op, a, d, rd);
  endtask

  task automatic ld(input logic [2:0] op, input logic [8:0] a, output logic [31:0] rd);
    cyc(1'b0, 1'b1, op, a, 32'h0, rd);
  endtask

  task automatic idle(input int n);
    logic [31:0] rd;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd2, 9'h0, 32'h0, rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] c;
    logic [2:0]  ops [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
    rst = 1'b1; memwrite = 1'b0; memread = 1'b0;
    memop = 3'd2; memaddr = 9'h0; memdatain = 32'h0;
    model_reset();
    #2;
    check("rst_dout", memdataout, 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Compare match, starting from cnt=0
    st(3'd2, 9'h1F4, 32'd10);
    idle(9);
    check("irq_before_match", 32'(irq), 32'h0);
    idle(1);
    check("irq_after_match", 32'(irq), 32'h1);
    st(3'd2, 9'h1F8, 32'h1);
    check("irq_cleared", 32'(irq), 32'h0);
    c = m_cnt;
    st(3'd2, 9'h1F4, c + 32'd2);
    idle(1);
    st(3'd2, 9'h1F8, 32'h1);
    check("irq_set_wins", 32'(irq), 32'h1);

    // Counter write and wrap
    st(3'd2, 9'h1F0, 32'hFFFF_FFFE);
    ld(3'd2, 9'h1F0, rd); check("cnt_0", rd, 32'hFFFF_FFFE);
    ld(3'd2, 9'h1F0, rd); check("cnt_1", rd, 32'hFFFF_FFFF);
    ld(3'd2, 9'h1F0, rd); check("cnt_wrap", rd, 32'h0);

    // Byte and half stores, signed and unsigned loads
    st(3'd2, 9'h010, 32'h1122_3344);
    st(3'd0, 9'h011, 32'h0000_00AB);
    st(3'd1, 9'h012, 32'h0000_8001);
    ld(3'd2, 9'h010, rd); check("lw_010", rd, 32'h8001_AB44);
    ld(3'd0, 9'h011, rd); check("lb_011", rd, 32'hFFFF_FFAB);
    ld(3'd4, 9'h011, rd); check("lbu_011", rd, 32'h0000_00AB);
    ld(3'd1, 9'h012, rd); check("lh_012", rd, 32'hFFFF_8001);
    ld(3'd5, 9'h012, rd); check("lhu_012", rd, 32'h0000_8001);

    // Misaligned accesses
    st(3'd2, 9'h022, 32'hDEAD_BEEF);
    check("err_misaligned_sw", 32'(err), 32'h1);
    st(3'd1, 9'h021, 32'h0000_1234);
    ld(3'd2, 9'h020, rd); check("word_020_kept", rd, 32'h0);
    ld(3'd2, 9'h022, rd); check("lw_misaligned", rd, 32'h0);
    st(3'd2, 9'h1F8, 32'h2);
    check("err_cleared", 32'(err), 32'h0);

    // Load and store to the same word in the same cycle
    st(3'd2, 9'h040, 32'h5);
    cyc(1'b1, 1'b1, 3'd2, 9'h040, 32'h9, rd);
    check("rdw_old", rd, 32'h5);
    ld(3'd2, 9'h040, rd); check("rdw_new", rd, 32'h9);

    // Illegal MMIO size, then LED
    st(3'd0, 9'h1FC, 32'hFF);
    check("led_sb_ignored", 32'(led), 32'h0);
    check("err_mmio_sb", 32'(err), 32'h1);
    st(3'd2, 9'h1FC, 32'h0001_A5A5);
    check("led_sw", 32'(led), 32'h0000_A5A5);
    ld(3'd2, 9'h1FC, rd); check("lw_led", rd, 32'h0000_A5A5);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [8:0] a;
      case ($urandom_range(0, 3))
        0:       a = 9'($urandom);
        1:       a = 9'($urandom_range(0, 31));
        2:       a = 9'h1F0 | 9'($urandom_range(0, 15));
        default: a = {4'b0, 3'($urandom_range(0, 7)), 2'b00};
      endcase
      cyc(1'($urandom), 1'($urandom), ops[$urandom_range(0, 7)], a, $urandom, rd);
    end

    // Asynchronous reset while a store is pending
    st(3'd2, 9'h1FC, 32'h0000_00FF);
    st(3'd0, 9'h1FD, 32'h0);
    memwrite = 1'b1; memread = 1'b0; memop = 3'd2;
    memaddr = 9'h000; memdatain = 32'h1234_5678;
    #2 rst = 1'b1;
    #1;
    check("arst_dout", memdataout, 32'h0);
    check("arst_led", 32'(led), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_err", 32'(err), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; memwrite = 1'b0;
    ld(3'd2, 9'h000, rd); check("word_000_after_rst", rd, 32'h0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
